// File: rtl/blend_frame_sequencer.sv
// Frame sequencer for a pixel blend core. Each pixel is read, loaded into the
// core operand registers, blended, captured and handed downstream in turn.
module blend_frame_sequencer #(
  parameter int ADDR_W       = 16,
  parameter int FRAME_PIXELS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_pix_t,
  input  logic [7:0]        rd_pix_t1,
  input  logic [7:0]        rd_mask,
  output logic [7:0]        core_pixel_t,
  output logic [7:0]        core_pixel_t1,
  output logic [7:0]        core_mask,
  input  logic [7:0]        core_pixel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_pixel,
  output logic [ADDR_W-1:0] out_addr
);

  typedef enum logic [2:0] {IDLE, READ, LOAD, CORE, CAPT, OUT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              handshake;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    handshake = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = READ;
      READ: state_nxt = LOAD;
      LOAD: state_nxt = CORE;
      CORE: state_nxt = CAPT;
      CAPT: state_nxt = OUT;
      OUT: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = (idx == LAST_IDX) ? DONE : READ;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort outranks everything, including a handshake in the same cycle.
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
      handshake = 1'b0;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      core_pixel_t  <= '0;
      core_pixel_t1 <= '0;
      core_mask     <= '0;
      out_pixel     <= '0;
      out_addr      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) idx <= '0;
      else if (handshake && idx != LAST_IDX) idx <= idx + ADDR_W'(1);
      if (state == LOAD) begin
        core_pixel_t  <= rd_pix_t;
        core_pixel_t1 <= rd_pix_t1;
        core_mask     <= rd_mask;
      end
      if (state == CAPT) begin
        out_pixel <= core_pixel_out;
        out_addr  <= idx;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_en     = (state == READ);
  assign rd_addr   = idx;
  assign out_valid = (state == OUT);

endmodule

// File: tb/tb_blend_frame_sequencer.sv
// Directed bench for blend_frame_sequencer: a 3-pixel frame with a behavioural
// memory and blend core, plus a second single-pixel instance.
module tb_blend_frame_sequencer;

  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, abort, out_ready;
  logic              busy, done, rd_en, out_valid;
  logic [ADDR_W-1:0] rd_addr, out_addr;
  logic [7:0]        rd_pix_t, rd_pix_t1, rd_mask;
  logic [7:0]        core_pixel_t, core_pixel_t1, core_mask, core_pixel_out, out_pixel;

  logic              start1, abort1, out_ready1;
  logic              busy1, done1, rd_en1, out_valid1;
  logic [ADDR_W-1:0] rd_addr1, out_addr1;
  logic [7:0]        rd_pix_t_1, rd_pix_t1_1, rd_mask_1;
  logic [7:0]        core_pixel_t_1, core_pixel_t1_1, core_mask_1, core_pixel_out1, out_pixel1;

  logic [7:0] mem_t  [3] = '{8'd100, 8'd100, 8'd100};
  logic [7:0] mem_t1 [3] = '{8'd200, 8'd200, 8'd200};
  logic [7:0] mem_m  [3] = '{8'd0,   8'd255, 8'd128};

  int checks   = 0;
  int failures = 0;
  int rd_cnt1  = 0;

  blend_frame_sequencer #(.ADDR_W(ADDR_W), .FRAME_PIXELS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_pix_t(rd_pix_t), .rd_pix_t1(rd_pix_t1), .rd_mask(rd_mask),
    .core_pixel_t(core_pixel_t), .core_pixel_t1(core_pixel_t1), .core_mask(core_mask),
    .core_pixel_out(core_pixel_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_addr(out_addr)
  );

  blend_frame_sequencer #(.ADDR_W(ADDR_W), .FRAME_PIXELS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_pix_t(rd_pix_t_1), .rd_pix_t1(rd_pix_t1_1), .rd_mask(rd_mask_1),
    .core_pixel_t(core_pixel_t_1), .core_pixel_t1(core_pixel_t1_1), .core_mask(core_mask_1),
    .core_pixel_out(core_pixel_out1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_pixel(out_pixel1), .out_addr(out_addr1)
  );

  // Blend core model: mask=0 selects t1, mask=255 selects t, rounded.
  function automatic logic [7:0] blend(input logic [7:0] t, input logic [7:0] t1,
                                       input logic [7:0] m);
    int acc;
    acc = int'(t1) * (255 - int'(m)) + int'(t) * int'(m) + 127;
    return 8'(acc / 255);
  endfunction

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_pix_t  <= mem_t[rd_addr[1:0]];
      rd_pix_t1 <= mem_t1[rd_addr[1:0]];
      rd_mask   <= mem_m[rd_addr[1:0]];
    end
    if (rd_en1) begin
      rd_pix_t_1  <= mem_t[rd_addr1[1:0]];
      rd_pix_t1_1 <= mem_t1[rd_addr1[1:0]];
      rd_mask_1   <= mem_m[rd_addr1[1:0]];
    end
    core_pixel_out  <= blend(core_pixel_t, core_pixel_t1, core_mask);
    core_pixel_out1 <= blend(core_pixel_t_1, core_pixel_t1_1, core_mask_1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rd_en1) rd_cnt1++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_pixel"}, 32'(out_pixel), 0);
    check({tag, "_out_addr"}, 32'(out_addr), 0);
    check({tag, "_core_ops"}, {8'd0, core_pixel_t, core_pixel_t1, core_mask}, 0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 0);
  endtask

  // Entered at the READ cycle; leaves the bench at the first OUT cycle.
  task automatic expect_pixel(input int addr, input int lo, input int hi);
    check($sformatf("rd_en_p%0d", addr), 32'(rd_en), 1);
    check($sformatf("rd_addr_p%0d", addr), 32'(rd_addr), 32'(addr));
    step(); step(); step();
    check($sformatf("valid_early_p%0d", addr), 32'(out_valid), 0);
    step();
    check($sformatf("valid_p%0d", addr), 32'(out_valid), 1);
    check($sformatf("out_addr_p%0d", addr), 32'(out_addr), 32'(addr));
    check($sformatf("out_pixel_p%0d(%0d)", addr, out_pixel), 32'(int'(out_pixel) >= lo && int'(out_pixel) <= hi), 1);
  endtask

  task automatic full_frame(input string tag);
    start = 1'b1; step(); start = 1'b0;
    expect_pixel(0, 200, 200); step();
    expect_pixel(1, 100, 100); step();
    expect_pixel(2, 149, 151); step();
    check({tag, "_done"}, 32'(done), 1);
    step();
    check({tag, "_done_clear"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1;
    step(); step();
    check_reset_outputs("por");
    rst_n = 1'b1;
    step(); step();
    check("idle_wait", 32'(busy), 0);

    // Basic 3-pixel frame; operands hold their last values in IDLE.
    full_frame("frame1");
    check("ops_hold", {8'd0, core_pixel_t, core_pixel_t1, core_mask}, {8'd0, 8'd100, 8'd200, 8'd128});
    step();
    check("done_once", 32'(done), 0);

    // Downstream stall of 7 cycles on pixel 1.
    start = 1'b1; step(); start = 1'b0;
    expect_pixel(0, 200, 200); step();
    out_ready = 1'b0;
    expect_pixel(1, 100, 100);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) out_ready = 1'b1;
      else step();
      check($sformatf("stall_hold_%0d", i), {15'd0, out_valid, out_pixel, out_addr[7:0]}, {15'd0, 1'b1, 8'd100, 8'd1});
    end
    step();
    check("stall_single_hs", {31'd0, rd_en}, 1);
    expect_pixel(2, 149, 151); step();
    check("stall_done", 32'(done), 1);
    step();

    // Abort in OUT of pixel 1 while out_ready is high.
    start = 1'b1; step(); start = 1'b0;
    expect_pixel(0, 200, 200); step();
    expect_pixel(1, 100, 100);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort_quiet_%0d", i), {30'd0, done, rd_en}, 0);
      step();
    end

    // start re-pulsed during CORE of pixel 0 is ignored.
    start = 1'b1; step(); start = 1'b0;
    check("restart_read0", 32'(rd_addr), 0);
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    check("restart_capt", {31'd0, rd_en}, 0);
    step();
    check("restart_out0", {23'd0, out_valid, out_pixel}, {23'd0, 1'b1, 8'd200});
    step();
    expect_pixel(1, 100, 100); step();
    expect_pixel(2, 149, 151); step();
    check("restart_done", 32'(done), 1);
    step();

    // Reset pulse during LOAD of pixel 2, then start+abort together.
    start = 1'b1; step(); start = 1'b0;
    expect_pixel(0, 200, 200); step();
    expect_pixel(1, 100, 100); step();
    check("rst_read2", 32'(rd_addr), 2);
    step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check_reset_outputs("midrst");
    step(); step();
    check("midrst_wait", 32'(busy), 0);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {30'd0, busy, rd_en}, 3);
    step(); step(); step(); step();
    check("sa_pixel0", {23'd0, out_valid, out_pixel}, {23'd0, 1'b1, 8'd200});
    step();
    expect_pixel(1, 100, 100); step();
    expect_pixel(2, 149, 151); step();
    check("sa_done", 32'(done), 1);
    step();
    full_frame("frame_after_rst");

    // Single-pixel frame on the second instance.
    rd_cnt1 = 0;
    check("fp1_idle", 32'(busy1), 0);
    start1 = 1'b1; step(); start1 = 1'b0;
    check("fp1_read", {15'd0, rd_en1, rd_addr1}, {15'd0, 1'b1, 16'd0});
    step(); step(); step(); step();
    check("fp1_out", {7'd0, out_valid1, out_pixel1, out_addr1}, {7'd0, 1'b1, 8'd200, 16'd0});
    step();
    check("fp1_done", {30'd0, done1, busy1}, 3);
    step();
    check("fp1_idle_after", {30'd0, done1, busy1}, 0);
    step(); step(); step();
    check("fp1_rd_pulses", 32'(rd_cnt1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blend_frame_sequencer.md
BLEND_FRAME_SEQUENCER -- requirements
Module: blend_frame_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16, pixel address width.
REQ-002 Parameter FRAME_PIXELS, default 64, pixels per frame, range 1..2^ADDR_W.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  frame start request; sampled only in IDLE.
REQ-006 abort  input  1  cancel the current frame; sampled in every non-IDLE state.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when a frame completes normally.
REQ-009 rd_en  output  1  source memory read strobe.
REQ-010 rd_addr  output  ADDR_W  pixel index being read.
REQ-011 rd_pix_t, rd_pix_t1, rd_mask  input  8 each  memory read data, valid exactly one cycle after rd_en.
REQ-012 core_pixel_t, core_pixel_t1, core_mask  output  8 each  registered operands to neural_core.
REQ-013 core_pixel_out  input  8  neural_core result, registered inside the core with 1-cycle latency.
REQ-014 out_valid  output  1  output pixel available.
REQ-015 out_ready  input  1  downstream accepts the pixel.
REQ-016 out_pixel  output  8  blended pixel.
REQ-017 out_addr  output  ADDR_W  index of out_pixel.

Function
REQ-018 The FSM SHALL use the states IDLE, READ, LOAD, CORE, CAPT, OUT and DONE, one pixel in flight at a time.
REQ-019 IDLE: start=1 -> READ with idx=0; start=0 -> stay in IDLE.
REQ-020 READ lasts 1 cycle, drives rd_en=1 and rd_addr=idx, then goes to LOAD; rd_en SHALL be 0 in every other state.
REQ-021 LOAD lasts 1 cycle; at its closing edge core_pixel_t/core_pixel_t1/core_mask SHALL load rd_pix_t/rd_pix_t1/rd_mask; then CORE.
REQ-022 Core operands SHALL hold their value in all other states, including IDLE after a frame.
REQ-023 CORE lasts 1 cycle (core register updates at its closing edge), then CAPT.
REQ-024 CAPT lasts 1 cycle; at its closing edge out_pixel SHALL load core_pixel_out and out_addr SHALL load idx; then OUT.
REQ-025 OUT: out_valid=1; out_pixel and out_addr stable until the handshake (out_valid and out_ready at the same edge).
REQ-026 On a handshake with idx<FRAME_PIXELS-1: idx increments and the FSM goes to READ.
REQ-027 On a handshake with idx==FRAME_PIXELS-1: the FSM goes to DONE.
REQ-028 DONE lasts 1 cycle with done=1, then IDLE; idx does not wrap past FRAME_PIXELS-1.
REQ-029 With out_ready held high, out_valid SHALL first rise in the 5th cycle after the start edge, and pixels SHALL be produced one per 5 cycles.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE at the next edge: done stays 0, out_valid drops, and no handshake occurs in that cycle even if out_ready=1.
REQ-031 Abort takes priority over a simultaneous handshake.
REQ-032 start asserted while busy SHALL be ignored; start and abort together in IDLE SHALL start a frame, since abort is ignored in IDLE.
REQ-033 out_ready low for any number of cycles SHALL stall in OUT with no lost or duplicated pixel.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE, idx=0, busy=0, done=0, rd_en=0, out_valid=0, out_pixel=0, out_addr=0 and all core operands 0.
REQ-035 Reset SHALL take effect in any state, including mid-frame; after release the block waits for a new start.

Verification
REQ-036 Bench instantiates neural_core with FRAME_PIXELS=3, memory {t,t1,mask} = {100,200,0}, {100,200,255}, {100,200,128}, out_ready=1, pulse start -> out_pixel 200, 100, 150±1 at out_addr 0,1,2, out_valid first in cycle 5, done pulse one cycle after the 3rd handshake.
REQ-037 Same frame with out_ready low for 7 cycles during pixel 1 -> out_pixel=100 held stable throughout, a single handshake, and the same final sequence.
REQ-038 abort asserted in OUT of pixel 1 with out_ready=1 -> no handshake for pixel 1, IDLE next cycle, done never pulses, busy=0.
REQ-039 start re-pulsed during CORE of pixel 0 -> no restart and rd_addr sequence 0,1,2 unchanged.
REQ-040 rst_n=0 for 1 cycle during LOAD of pixel 2 -> all outputs at reset values next cycle; a new start then yields a full 3-pixel frame from address 0.
REQ-041 FRAME_PIXELS=1 -> one output, done, IDLE, rd_en pulsed exactly once.
